// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - measures PWM high time per period, flags period errors and stuck inputs
module pwm_duty_decoder #(
   parameter int PERIOD_CLKS = 100,
   parameter int PERIOD_TOL  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       PWM_IN,
   output logic [7:0] DUTY_CYCLE,
   output logic       DUTY_VALID,
   output logic       PERIOD_ERR,
   output logic       LOCKED
);

   typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

   localparam logic [8:0] PERIOD_C = 9'(PERIOD_CLKS);
   localparam logic [8:0] STUCK_C  = 9'(2 * PERIOD_CLKS);
   localparam logic [8:0] TOL_C    = 9'(PERIOD_TOL);
   localparam logic [8:0] CNT_MAX  = 9'h1ff;

   state_t     state;
   logic       sync1, s, s_d;
   logic       rise;
   logic [8:0] period_cnt, high_cnt;
   logic [8:0] period_nxt, high_nxt;
   logic [8:0] diff_abs;
   logic       in_tol;
   logic [7:0] duty_sat, stuck_duty;

   assign rise = s & ~s_d;

   always_comb begin
      period_nxt = (period_cnt == CNT_MAX) ? period_cnt : period_cnt + 9'd1;
      high_nxt   = (high_cnt == CNT_MAX || !s) ? high_cnt : high_cnt + 9'd1;
      if (period_cnt >= PERIOD_C)
         diff_abs = period_cnt - PERIOD_C;
      else
         diff_abs = PERIOD_C - period_cnt;
      in_tol     = (diff_abs <= TOL_C);
      duty_sat   = (high_cnt > 9'd255) ? 8'hff : high_cnt[7:0];
      // A stuck-high line reads as a full period of high time.
      stuck_duty = s ? 8'(PERIOD_CLKS) : 8'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sync1      <= 1'b0;
         s          <= 1'b0;
         s_d        <= 1'b0;
         period_cnt <= 9'd0;
         high_cnt   <= 9'd0;
         DUTY_CYCLE <= 8'd0;
         DUTY_VALID <= 1'b0;
         PERIOD_ERR <= 1'b0;
         LOCKED     <= 1'b0;
      end else begin
         sync1      <= PWM_IN;
         s          <= sync1;
         s_d        <= s;
         DUTY_VALID <= 1'b0;
         PERIOD_ERR <= 1'b0;

         if (rise) begin
            period_cnt <= 9'd1;
            high_cnt   <= 9'd1;
         end else begin
            period_cnt <= period_nxt;
            high_cnt   <= high_nxt;
         end

         case (state)
            IDLE, MEASURE: begin
               if (rise) begin
                  // The first rise out of IDLE only opens a measurement window.
                  if (state == MEASURE) begin
                     if (in_tol) begin
                        DUTY_CYCLE <= duty_sat;
                        DUTY_VALID <= 1'b1;
                        LOCKED     <= 1'b1;
                     end else begin
                        PERIOD_ERR <= 1'b1;
                        LOCKED     <= 1'b0;
                     end
                  end
                  state <= MEASURE;
               end else if (period_cnt >= STUCK_C) begin
                  DUTY_CYCLE <= stuck_duty;
                  DUTY_VALID <= 1'b1;
                  LOCKED     <= 1'b0;
                  period_cnt <= 9'd1;
                  state      <= STUCK;
               end
            end
            STUCK: begin
               if (rise) begin
                  state <= MEASURE;
               end else if (period_cnt >= PERIOD_C) begin
                  DUTY_VALID <= 1'b1;
                  period_cnt <= 9'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
